// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the fetch unit's state encoding.
package riscv;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;

   typedef enum logic [1:0] {BOOT, FETCH, DRAIN} fetch_state_t;

endpackage

// File: rtl/ifetch_fetch_buffer.sv
// Two-entry FIFO used both as the in-flight PC queue and as the decode-side
// instruction buffer. Flush only rewinds pointers; stale payload stays behind.
module fetch_buffer #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [1:0]        count_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        count_q;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0);
   // A push into a full buffer is only taken when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, keeps at most two instructions outstanding
// or buffered, and drains old-path responses after a branch redirect.
module ifetch import riscv::*; #(
   parameter int unsigned          XLEN         = riscv::XLEN,
   parameter logic [XLEN-1:0]      RESET_VECTOR = riscv::RESET_VECTOR
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            branch_v_i,
   input  logic [XLEN-1:0] pc_nxt_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            dec_valid_o,
   output logic [31:0]     dec_instr_o,
   output logic [XLEN-1:0] dec_pc_o,
   input  logic            dec_ready_i
);

   fetch_state_t       state_q, state_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [1:0]         drop_cnt, drop_d;

   logic [XLEN-1:0]    infl_head;
   logic               infl_full, infl_empty;
   logic [1:0]         infl_cnt;
   logic [XLEN+31:0]   buf_head;
   logic               buf_full, buf_empty;
   logic [1:0]         buf_cnt;

   logic               redirect;
   logic               fetch_req;
   logic               grant;
   logic               rsp_hit;
   logic               drop_hit;
   logic               buf_pop;
   logic [2:0]         out_after;

   assign redirect  = branch_v_i && (state_q != BOOT);
   // Depends only on registered counts, never on this cycle's handshakes.
   assign fetch_req = (state_q == FETCH) && !infl_full && !buf_full &&
                      (({1'b0, infl_cnt} + {1'b0, buf_cnt}) < 3'd2);
   assign grant     = fetch_req && imem_gnt_i;
   assign rsp_hit   = imem_rvalid_i && (state_q == FETCH) && !infl_empty;
   assign drop_hit  = imem_rvalid_i && (state_q == DRAIN) && (drop_cnt != 2'd0);
   assign buf_pop   = dec_valid_o && dec_ready_i;

   // Requests still owed a response once this cycle's grant and response settle.
   assign out_after = {1'b0, infl_cnt} + {1'b0, drop_cnt} + {2'b00, grant}
                      - {2'b00, (rsp_hit || drop_hit)};

   fetch_buffer #(.DATA_W(XLEN)) u_infl_q (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (redirect),
      .push_i      (grant),
      .push_data_i (pc_q),
      .pop_i       (rsp_hit),
      .head_o      (infl_head),
      .full_o      (infl_full),
      .empty_o     (infl_empty),
      .count_o     (infl_cnt)
   );

   fetch_buffer #(.DATA_W(XLEN + 32)) u_instr_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (redirect),
      .push_i      (rsp_hit && !redirect),
      .push_data_i ({infl_head, imem_rdata_i}),
      .pop_i       (buf_pop),
      .head_o      (buf_head),
      .full_o      (buf_full),
      .empty_o     (buf_empty),
      .count_o     (buf_cnt)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_cnt;
      case (state_q)
         BOOT:  state_d = FETCH;
         FETCH: begin
            if (grant) pc_d = pc_q + XLEN'(4);
         end
         DRAIN: begin
            drop_d = out_after[1:0];
            if (out_after == 3'd0) state_d = FETCH;
         end
         default: state_d = BOOT;
      endcase
      if (redirect) begin
         pc_d    = {pc_nxt_i[XLEN-1:2], 2'b00};
         drop_d  = out_after[1:0];
         state_d = (out_after == 3'd0) ? FETCH : DRAIN;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= BOOT;
         pc_q     <= RESET_VECTOR;
         drop_cnt <= 2'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drop_cnt <= drop_d;
      end
   end

   assign imem_req_o  = fetch_req;
   assign imem_addr_o = pc_q;
   assign dec_valid_o = !buf_empty;
   assign dec_pc_o    = buf_head[XLEN+31:32];
   assign dec_instr_o = buf_head[31:0];

endmodule

// File: tb/tb_ifetch.sv
// Directed, table-driven bench for ifetch with hand-computed cycle traces.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        branch_v_i;
   logic [31:0] pc_nxt_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        dec_valid_o;
   logic [31:0] dec_instr_o;
   logic [31:0] dec_pc_o;
   logic        dec_ready_i;

   always #5 clk = ~clk;

   ifetch dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .branch_v_i    (branch_v_i),
      .pc_nxt_i      (pc_nxt_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .dec_valid_o   (dec_valid_o),
      .dec_instr_o   (dec_instr_o),
      .dec_pc_o      (dec_pc_o),
      .dec_ready_i   (dec_ready_i)
   );

   typedef struct {
      logic        start;
      logic        br;
      logic [31:0] pcn;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        dv;
      logic [31:0] dpc;
      logic [31:0] dinstr;
      logic [1:0]  drop;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic vec_t mk(input logic start, input logic br, input logic [31:0] pcn,
                               input logic gnt, input logic rv, input logic [31:0] rdata,
                               input logic rdy, input logic req, input logic [31:0] addr,
                               input logic dv, input logic [31:0] dpc,
                               input logic [31:0] dinstr, input logic [1:0] drop);
      vec_t v;
      v.start = start; v.br = br; v.pcn = pcn; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.rdy = rdy; v.req = req; v.addr = addr; v.dv = dv; v.dpc = dpc;
      v.dinstr = dinstr; v.drop = drop;
      return v;
   endfunction

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got %h, want %h", what, act, exp);
         n_miss++;
      end
   endtask

   task automatic drive(input logic br, input logic [31:0] pcn, input logic gnt,
                        input logic rv, input logic [31:0] rdata, input logic rdy);
      branch_v_i    = br;
      pc_nxt_i      = pcn;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rdata;
      dec_ready_i   = rdy;
   endtask

   task automatic chk_reset_values(input string tag);
      n_vec++;
      chk({tag, " req"},    {31'b0, imem_req_o},  32'h0);
      chk({tag, " addr"},   imem_addr_o,          32'h8000_0000);
      chk({tag, " dvalid"}, {31'b0, dec_valid_o}, 32'h0);
      chk({tag, " dpc"},    dec_pc_o,             32'h0);
      chk({tag, " dinstr"}, dec_instr_o,          32'h0);
      chk({tag, " drop"},   {30'b0, dut.drop_cnt}, 32'h0);
   endtask

   // Leaves the bench just after the negedge at which reset_n rises (cycle 1).
   task automatic do_reset();
      reset_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk_reset_values("reset");
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         vec_t v;
         string tag;
         v = tbl[i];
         tag = $sformatf("row%0d", i);
         if (v.start) do_reset();
         n_vec++;
         chk({tag, " req"},    {31'b0, imem_req_o},   {31'b0, v.req});
         chk({tag, " addr"},   imem_addr_o,           v.addr);
         chk({tag, " dvalid"}, {31'b0, dec_valid_o},  {31'b0, v.dv});
         chk({tag, " drop"},   {30'b0, dut.drop_cnt}, {30'b0, v.drop});
         if (v.dv) begin
            chk({tag, " dpc"},    dec_pc_o,    v.dpc);
            chk({tag, " dinstr"}, dec_instr_o, v.dinstr);
         end
         drive(v.br, v.pcn, v.gnt, v.rv, v.rdata, v.rdy);
         @(negedge clk);
         #1;
      end
   endtask

   int seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_end;

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

      // Streaming: grant always, response one cycle after grant, decode always ready.
      seg_a = tbl.size();
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'h1111_1111, 1, 1, 32'h8000_0004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'h2222_2222, 1, 0, 32'h8000_0008, 1, 32'h8000_0000, 32'h1111_1111, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8000_0008, 1, 32'h8000_0004, 32'h2222_2222, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'h3333_3333, 1, 1, 32'h8000_000C, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0010, 1, 32'h8000_0008, 32'h3333_3333, 0));

      // Backpressure: decode stalled, then a single ready pulse.
      seg_b = tbl.size();
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'hAAAA_0000, 0, 0, 32'h8000_0008, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'hBBBB_0004, 0, 0, 32'h8000_0008, 1, 32'h8000_0000, 32'hAAAA_0000, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0008, 1, 32'h8000_0000, 32'hAAAA_0000, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h8000_0008, 1, 32'h8000_0000, 32'hAAAA_0000, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0008, 1, 32'h8000_0004, 32'hBBBB_0004, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_000C, 1, 32'h8000_0004, 32'hBBBB_0004, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_000C, 1, 32'h8000_0004, 32'hBBBB_0004, 0));

      // Redirect to an unaligned target with two requests in flight.
      seg_c = tbl.size();
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h8000_1002, 1, 0, 0, 0, 0, 32'h8000_0008, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'hDEAD_0000, 1, 0, 32'h8000_1000, 0, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'hDEAD_0004, 1, 0, 32'h8000_1000, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8000_1000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'hCAFE_1000, 1, 1, 32'h8000_1004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h8000_1004, 1, 32'h8000_1000, 32'hCAFE_1000, 0));

      // Redirect in the same cycle as a grant and a response.
      seg_d = tbl.size();
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h8000_2000, 1, 1, 32'hBAD0_0000, 1, 1, 32'h8000_0004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'hBAD0_0004, 1, 0, 32'h8000_2000, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8000_2000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h1234_5678, 1, 1, 32'h8000_2004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h8000_2004, 1, 32'h8000_2000, 32'h1234_5678, 0));

      // PC wrap: redirect to the last word, then fetch past it.
      seg_e = tbl.size();
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0013, 1, 1, 32'h0000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_0013, 0));

      // Into DRAIN with two requests outstanding; reset follows by hand.
      seg_f = tbl.size();
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0004, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h8000_1000, 0, 0, 0, 0, 0, 32'h8000_0008, 0, 0, 0, 0));

      // Restart after the mid-DRAIN reset.
      seg_g = tbl.size();
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0004, 0, 0, 0, 0));
      seg_end = tbl.size();

      run_rows(seg_a, seg_b - 1);
      run_rows(seg_b, seg_c - 1);
      run_rows(seg_c, seg_d - 1);
      run_rows(seg_d, seg_e - 1);
      run_rows(seg_e, seg_f - 1);
      run_rows(seg_f, seg_g - 1);

      n_vec++;
      chk("drain req",  {31'b0, imem_req_o},   32'h0);
      chk("drain addr", imem_addr_o,           32'h8000_1000);
      chk("drain drop", {30'b0, dut.drop_cnt}, 32'h2);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_values("async reset");

      run_rows(seg_g, seg_end - 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
